// File: rtl/chip8_fetch_seq_if.sv
// Sequencer-side bus: instruction memory port, execute handshake, status.
// master = sequencer, slave = memory/execute side.
interface chip8_fetch_seq_if;
    logic [15:0] pc;
    logic [15:0] ir;
    logic [7:0]  v0;
    logic        op_valid;
    logic        op_ready;
    logic [15:0] op;
    logic        ex_done;
    logic        ex_skip;
    logic        halted;
    logic [1:0]  fault;

    modport master (
        output pc, op_valid, op, halted, fault,
        input  ir, v0, op_ready, ex_done, ex_skip
    );

    modport slave (
        input  pc, op_valid, op, halted, fault,
        output ir, v0, op_ready, ex_done, ex_skip
    );
endinterface

// File: rtl/chip8_fetch_seq.sv
// CHIP-8 program sequencer: fetch, local control flow, execute handoff.
// Optional: SELF_LOOP_HALT_EN halts on a 1NNN that targets its own pc.
module chip8_fetch_seq #(
    parameter int          STACK_DEPTH = 16,
    parameter logic [11:0] LOAD_BASE   = 12'h200
) (
    input  logic clk,
    input  logic rst_n,
    chip8_fetch_seq_if.master bus
);
    localparam int AW  = $clog2(STACK_DEPTH);
    localparam int SPW = AW + 1;

    typedef enum logic [2:0] {
        FETCH, LOAD, DECODE, ISSUE, WAIT_EX, HALT
    } state_t;

    state_t         state;
    logic [11:0]    pc_q;
    logic [SPW-1:0] sp;
    logic [SPW-1:0] sp_dec;
    logic [11:0]    stack [STACK_DEPTH];

    logic        is_ret, is_jp, is_call, is_jpv0;
    logic [11:0] jp_tgt, ret_tgt;
    logic [12:0] bnnn_sum;
    logic [11:0] nxt_pc;
    logic [1:0]  nxt_fault;
    logic        issue;
    logic        loop_halt;
    logic        push;

    assign is_ret  = bus.ir == 16'h00EE;
    assign is_jp   = bus.ir[15:12] == 4'h1;
    assign is_call = bus.ir[15:12] == 4'h2;
    assign is_jpv0 = bus.ir[15:12] == 4'hB;

    assign sp_dec   = sp - SPW'(1);
    assign jp_tgt   = bus.ir[11:0] - LOAD_BASE;
    assign ret_tgt  = stack[sp_dec[AW-1:0]] + 12'd2;
    // 13-bit sum so NNN+V0 carries before the base is removed
    assign bnnn_sum = 13'(bus.ir[11:0]) + 13'(bus.v0)
                    - 13'(LOAD_BASE);

`ifdef SELF_LOOP_HALT_EN
    assign loop_halt = is_jp && (jp_tgt == pc_q);
`else
    assign loop_halt = 1'b0;
`endif

    always_comb begin
        nxt_pc    = pc_q;
        nxt_fault = 2'd0;
        issue     = 1'b0;
        unique case (1'b1)
            is_ret: begin
                if (sp == '0) nxt_fault = 2'd2;
                else          nxt_pc = ret_tgt;
            end
            is_jp: nxt_pc = jp_tgt;
            is_call: begin
                if (sp == SPW'(STACK_DEPTH)) nxt_fault = 2'd1;
                else                         nxt_pc = jp_tgt;
            end
            is_jpv0: nxt_pc = bnnn_sum[11:0];
            default: issue = 1'b1;
        endcase
        if (nxt_fault == 2'd0 && nxt_pc[0]) nxt_fault = 2'd3;
    end

    assign push = (state == DECODE) && is_call
               && (nxt_fault == 2'd0);

    always_ff @(posedge clk) begin
        if (push) stack[sp[AW-1:0]] <= pc_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= FETCH;
            pc_q         <= '0;
            sp           <= '0;
            bus.op       <= '0;
            bus.op_valid <= 1'b0;
            bus.halted   <= 1'b0;
            bus.fault    <= 2'd0;
        end else begin
            unique case (state)
                FETCH: state <= LOAD;
                LOAD:  state <= DECODE;
                DECODE: begin
                    bus.op <= bus.ir;
                    if (issue) begin
                        bus.op_valid <= 1'b1;
                        state        <= ISSUE;
                    end else if (nxt_fault != 2'd0) begin
                        bus.fault  <= nxt_fault;
                        bus.halted <= 1'b1;
                        state      <= HALT;
                        if (nxt_fault == 2'd3) pc_q <= nxt_pc;
                    end else if (loop_halt) begin
                        bus.halted <= 1'b1;
                        state      <= HALT;
                    end else begin
                        pc_q  <= nxt_pc;
                        state <= FETCH;
                        if (is_ret)  sp <= sp_dec;
                        if (is_call) sp <= sp + SPW'(1);
                    end
                end
                ISSUE: begin
                    if (bus.op_ready) begin
                        bus.op_valid <= 1'b0;
                        state        <= WAIT_EX;
                    end
                end
                WAIT_EX: begin
                    if (bus.ex_done) begin
                        pc_q  <= pc_q + (bus.ex_skip ? 12'd4 : 12'd2);
                        state <= FETCH;
                    end
                end
                HALT: state <= HALT;
                default: state <= HALT;
            endcase
        end
    end

    assign bus.pc = {4'b0000, pc_q};
endmodule

// File: tb/tb_chip8_fetch_seq.sv
// Directed bench for chip8_fetch_seq with a synchronous word memory.
// Define SELF_LOOP_HALT_EN here and in the RTL build to test the option.
module tb_chip8_fetch_seq;
    logic clk = 1'b0;
    logic rst_n;
    int   checks = 0;
    int   errors = 0;
    logic [15:0] mem [2048];

    chip8_fetch_seq_if bus ();

    chip8_fetch_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    always @(posedge clk) bus.ir <= mem[bus.pc[11:1]];

    task automatic tick(input int n);
        for (int i = 0; i < n; i++) @(negedge clk);
    endtask

    task automatic clear_mem;
        for (int i = 0; i < 2048; i++) mem[i] = 16'h0000;
    endtask

    task automatic do_reset;
        rst_n        = 1'b0;
        bus.op_ready = 1'b0;
        bus.ex_done  = 1'b0;
        bus.ex_skip  = 1'b0;
        tick(2);
        rst_n = 1'b1;
    endtask

    task automatic test_reset;
        clear_mem();
        bus.v0 = 8'h00;
        rst_n  = 1'b0;
        bus.op_ready = 1'b0;
        bus.ex_done  = 1'b0;
        bus.ex_skip  = 1'b0;
        tick(2);
        checks++;
        if (bus.pc !== 16'h0000) begin
            errors++;
            $display("FAIL reset_pc got %h want 0000", bus.pc);
        end
        checks++;
        if (bus.op !== 16'h0000) begin
            errors++;
            $display("FAIL reset_op got %h want 0000", bus.op);
        end
        checks++;
        if (bus.op_valid !== 1'b0 || bus.halted !== 1'b0) begin
            errors++;
            $display("FAIL reset_flags valid %b halted %b want 0 0",
                     bus.op_valid, bus.halted);
        end
        checks++;
        if (bus.fault !== 2'd0) begin
            errors++;
            $display("FAIL reset_fault got %0d want 0", bus.fault);
        end
        rst_n = 1'b1;
    endtask

    task automatic test_issue;
        clear_mem();
        mem[0] = 16'h6A05;
        do_reset();
        tick(2);
        checks++;
        if (bus.op_valid !== 1'b0) begin
            errors++;
            $display("FAIL issue_early got %b want 0", bus.op_valid);
        end
        tick(1);
        checks++;
        if (bus.op_valid !== 1'b1 || bus.op !== 16'h6A05) begin
            errors++;
            $display("FAIL issue_offer valid %b op %h want 1 6a05",
                     bus.op_valid, bus.op);
        end
        bus.op_ready = 1'b1;
        tick(1);
        bus.op_ready = 1'b0;
        checks++;
        if (bus.op_valid !== 1'b0) begin
            errors++;
            $display("FAIL issue_drop got %b want 0", bus.op_valid);
        end
        bus.ex_done = 1'b1;
        tick(1);
        bus.ex_done = 1'b0;
        checks++;
        if (bus.pc !== 16'h0002) begin
            errors++;
            $display("FAIL issue_pc got %h want 0002", bus.pc);
        end
    endtask

    task automatic test_jump;
        clear_mem();
        mem[0] = 16'h1208;
        do_reset();
        for (int i = 0; i < 3; i++) begin
            tick(1);
            checks++;
            if (bus.op_valid !== 1'b0) begin
                errors++;
                $display("FAIL jump_valid cyc %0d got %b want 0",
                         i, bus.op_valid);
            end
        end
        checks++;
        if (bus.pc !== 16'h0008) begin
            errors++;
            $display("FAIL jump_pc got %h want 0008", bus.pc);
        end
    endtask

    task automatic test_call_ret;
        clear_mem();
        mem[0]    = 16'h1204;
        mem[2]    = 16'h2300;
        mem[12'h80] = 16'h00EE;
        do_reset();
        tick(3);
        checks++;
        if (bus.pc !== 16'h0004) begin
            errors++;
            $display("FAIL call_pre got %h want 0004", bus.pc);
        end
        tick(3);
        checks++;
        if (bus.pc !== 16'h0100 || dut.sp !== 5'd1) begin
            errors++;
            $display("FAIL call_pc pc %h sp %0d want 0100 1",
                     bus.pc, dut.sp);
        end
        tick(3);
        checks++;
        if (bus.pc !== 16'h0006 || dut.sp !== 5'd0) begin
            errors++;
            $display("FAIL ret_pc pc %h sp %0d want 0006 0",
                     bus.pc, dut.sp);
        end
    endtask

    task automatic test_skip;
        clear_mem();
        mem[0] = 16'h1202;
        mem[1] = 16'h3A05;
        do_reset();
        tick(6);
        checks++;
        if (bus.op_valid !== 1'b1 || bus.op !== 16'h3A05) begin
            errors++;
            $display("FAIL skip_offer valid %b op %h want 1 3a05",
                     bus.op_valid, bus.op);
        end
        bus.op_ready = 1'b1;
        bus.ex_done  = 1'b1;
        bus.ex_skip  = 1'b1;
        tick(1);
        bus.op_ready = 1'b0;
        bus.ex_done  = 1'b0;
        tick(2);
        checks++;
        if (bus.pc !== 16'h0002) begin
            errors++;
            $display("FAIL skip_early_done got %h want 0002", bus.pc);
        end
        bus.ex_done = 1'b1;
        tick(1);
        bus.ex_done = 1'b0;
        bus.ex_skip = 1'b0;
        checks++;
        if (bus.pc !== 16'h0006) begin
            errors++;
            $display("FAIL skip_pc got %h want 0006", bus.pc);
        end
    endtask

    task automatic test_overflow;
        clear_mem();
        mem[0] = 16'h2200;
        do_reset();
        tick(48);
        checks++;
        if (bus.halted !== 1'b0 || dut.sp !== 5'd16) begin
            errors++;
            $display("FAIL ovf_16 halted %b sp %0d want 0 16",
                     bus.halted, dut.sp);
        end
        tick(3);
        checks++;
        if (bus.halted !== 1'b1 || bus.fault !== 2'd1) begin
            errors++;
            $display("FAIL ovf_17 halted %b fault %0d want 1 1",
                     bus.halted, bus.fault);
        end
    endtask

    task automatic test_underflow;
        clear_mem();
        mem[0] = 16'h00EE;
        do_reset();
        tick(3);
        checks++;
        if (bus.halted !== 1'b1 || bus.fault !== 2'd2) begin
            errors++;
            $display("FAIL udf halted %b fault %0d want 1 2",
                     bus.halted, bus.fault);
        end
    endtask

    task automatic test_bnnn;
        clear_mem();
        mem[0] = 16'hB2FF;
        bus.v0 = 8'h01;
        do_reset();
        tick(3);
        checks++;
        if (bus.pc !== 16'h0100 || bus.halted !== 1'b0) begin
            errors++;
            $display("FAIL bnnn_even pc %h halted %b want 0100 0",
                     bus.pc, bus.halted);
        end
        bus.v0 = 8'h02;
        do_reset();
        tick(3);
        checks++;
        if (bus.halted !== 1'b1 || bus.fault !== 2'd3
            || bus.pc !== 16'h0101) begin
            errors++;
            $display("FAIL bnnn_odd h %b f %0d pc %h want 1 3 0101",
                     bus.halted, bus.fault, bus.pc);
        end
        bus.v0 = 8'h00;
    endtask

    task automatic test_self_loop;
        clear_mem();
        mem[0] = 16'h1200;
        do_reset();
        tick(3);
`ifdef SELF_LOOP_HALT_EN
        checks++;
        if (bus.halted !== 1'b1 || bus.fault !== 2'd0) begin
            errors++;
            $display("FAIL loop_halt h %b f %0d want 1 0",
                     bus.halted, bus.fault);
        end
`else
        checks++;
        if (bus.halted !== 1'b0 || bus.pc !== 16'h0000) begin
            errors++;
            $display("FAIL loop_run h %b pc %h want 0 0000",
                     bus.halted, bus.pc);
        end
`endif
        tick(6);
        checks++;
        if (bus.pc !== 16'h0000 || bus.op_valid !== 1'b0) begin
            errors++;
            $display("FAIL loop_hold pc %h valid %b want 0000 0",
                     bus.pc, bus.op_valid);
        end
    endtask

    task automatic test_reset_mid;
        clear_mem();
        mem[0] = 16'h6A05;
        do_reset();
        tick(3);
        rst_n = 1'b0;
        #1;
        checks++;
        if (bus.op_valid !== 1'b0 || bus.op !== 16'h0000) begin
            errors++;
            $display("FAIL mid_reset valid %b op %h want 0 0000",
                     bus.op_valid, bus.op);
        end
        rst_n = 1'b1;
    endtask

    initial begin
        test_reset();
        test_issue();
        test_jump();
        test_call_ret();
        test_skip();
        test_overflow();
        test_underflow();
        test_bnnn();
        test_self_loop();
        test_reset_mid();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
